// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command responder: opcodes, status codes,
// byte offsets of the command and response frames, and the frame checksum.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_EXEC,
    S_BUILD,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_HDR  = 8'h01;
  localparam logic [7:0] ST_BAD_CKS  = 8'h02;
  localparam logic [7:0] ST_BAD_OP   = 8'h03;
  localparam logic [7:0] ST_BAD_ADDR = 8'h04;
  localparam logic [7:0] ST_RO_ADDR  = 8'h05;

  // command frame, byte index (byte 7 is first on the wire)
  localparam int RX_BYTES  = 8;
  localparam int RX_HDR_B  = 7;
  localparam int RX_OP_B   = 6;
  localparam int RX_ADDR_B = 5;
  localparam int RX_DATA_B = 1;
  localparam int RX_CKS_B  = 0;

  // response frame, byte index (byte 17 is first on the wire)
  localparam int TX_BYTES  = 18;
  localparam int TX_HDR_B  = 17;
  localparam int TX_OP_B   = 16;
  localparam int TX_ST_B   = 15;
  localparam int TX_ADDR_B = 14;
  localparam int TX_DATA_B = 10;
  localparam int TX_RXC_B  = 8;
  localparam int TX_ERRC_B = 6;
  localparam int TX_CKS_B  = 0;

  // Modular 8-bit sum of bytes nbytes-1 down to 1; byte 0 holds the checksum itself.
  function automatic logic [7:0] sum8(input logic [143:0] v, input int nbytes);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 1; i < 18; i++) begin
      if (i < nbytes) s = s + v[8*i +: 8];
    end
    return s;
  endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Frame handshake between the UART frame controller (master) and the
// command responder (slave).
interface uart_cmd_responder_if;
  logic [63:0]  rx_data;
  logic         rx_rdy;
  logic         rx_ack;
  logic [143:0] tx_data;
  logic         tx_vld;
  logic         tx_rdy;

  modport master (
    output rx_data, rx_rdy, tx_rdy,
    input  rx_ack, tx_data, tx_vld
  );

  modport slave (
    input  rx_data, rx_rdy, tx_rdy,
    output rx_ack, tx_data, tx_vld
  );
endinterface

// File: rtl/uart_cmd_regfile.sv
// 32-bit register file; register 0 is a read-only device ID.
module uart_cmd_regfile #(
  parameter int          REG_NUM = 16,
  parameter logic [31:0] DEV_ID  = 32'h4E55_4649
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [7:0]             addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic [32*REG_NUM-1:0]  cfg_regs
);

  logic [31:0] regs_q [1:REG_NUM-1];

  // writable registers; writes to address 0 or out of range are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if ({24'd0, addr} == 32'(i)) regs_q[i] <= wdata;
      end
    end
  end

  // asynchronous read; out-of-range addresses read as zero
  always_comb begin
    rdata = '0;
    if (addr == 8'd0) rdata = DEV_ID;
    for (int i = 1; i < REG_NUM; i++) begin
      if ({24'd0, addr} == 32'(i)) rdata = regs_q[i];
    end
  end

  // flattened view of the whole file
  always_comb begin
    cfg_regs       = '0;
    cfg_regs[31:0] = DEV_ID;
    for (int i = 1; i < REG_NUM; i++) cfg_regs[32*i +: 32] = regs_q[i];
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Host command endpoint: accepts 8-byte command frames, executes them
// against the register file and returns an 18-byte response frame.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for rx_rdy; frame latched and acked on entry to ACK
// S_ACK       | ack pulse ends; validity checks registered, rx_cnt bumped
// S_EXEC      | register write/read, error counter and err_pulse
// S_BUILD     | response frame and checksum assembled into tx_data
// S_SEND      | waiting for tx_rdy, then pulse tx_vld
// S_WAIT_BUSY | one blind cycle: controller drops tx_rdy one cycle late
// S_WAIT_DONE | waiting for tx_rdy to signal the transmit finished
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int          REG_NUM = 16,
  parameter logic [31:0] DEV_ID  = 32'h4E55_4649,
  parameter logic [7:0]  RX_HDR  = 8'hA5,
  parameter logic [7:0]  TX_HDR  = 8'h5A
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_cmd_responder_if.slave   bus,
  output logic [32*REG_NUM-1:0] cfg_regs,
  output logic                  busy,
  output logic                  err_pulse
);

  state_t        state_q, state_d;
  logic          ack_set, send_fire;
  logic [63:0]   frame_q;
  logic [7:0]    status_q, status_c;
  logic [31:0]   data_q;
  logic [15:0]   rx_cnt_q, err_cnt_q;
  logic          rx_ack_q, tx_vld_q, err_pulse_q;
  logic [143:0]  tx_data_q, tx_c;
  logic [7:0]    f_hdr, f_op, f_addr, f_cks;
  logic [31:0]   f_data, rdata;
  logic          addr_oob, reg_we;

  assign f_hdr  = frame_q[8*RX_HDR_B  +: 8];
  assign f_op   = frame_q[8*RX_OP_B   +: 8];
  assign f_addr = frame_q[8*RX_ADDR_B +: 8];
  assign f_data = frame_q[8*RX_DATA_B +: 32];
  assign f_cks  = frame_q[8*RX_CKS_B  +: 8];

  assign addr_oob = {24'd0, f_addr} >= 32'(REG_NUM);
  assign reg_we   = (state_q == S_EXEC) && (status_q == ST_OK) && (f_op == OP_WRITE);

  assign bus.rx_ack = rx_ack_q;
  assign bus.tx_vld = tx_vld_q;
  assign bus.tx_data = tx_data_q;
  assign err_pulse  = err_pulse_q;
  assign busy       = (state_q != S_IDLE);

  uart_cmd_regfile #(
    .REG_NUM (REG_NUM),
    .DEV_ID  (DEV_ID)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (reg_we),
    .addr     (f_addr),
    .wdata    (f_data),
    .rdata    (rdata),
    .cfg_regs (cfg_regs)
  );

  // frame validation; the first failing check decides the status
  always_comb begin
    status_c = ST_OK;
    if (f_hdr != RX_HDR)
      status_c = ST_BAD_HDR;
    else if (f_cks != sum8({80'd0, frame_q}, RX_BYTES))
      status_c = ST_BAD_CKS;
    else if (!(f_op inside {OP_WRITE, OP_READ, OP_STATUS}))
      status_c = ST_BAD_OP;
    else if ((f_op != OP_STATUS) && addr_oob)
      status_c = ST_BAD_ADDR;
    else if ((f_op == OP_WRITE) && (f_addr == 8'd0))
      status_c = ST_RO_ADDR;
  end

  // response frame image, checksum computed over the assembled bytes
  always_comb begin
    tx_c = '0;
    tx_c[8*TX_HDR_B  +: 8]  = TX_HDR;
    tx_c[8*TX_OP_B   +: 8]  = f_op;
    tx_c[8*TX_ST_B   +: 8]  = status_q;
    tx_c[8*TX_ADDR_B +: 8]  = f_addr;
    tx_c[8*TX_DATA_B +: 32] = data_q;
    tx_c[8*TX_RXC_B  +: 16] = rx_cnt_q;
    tx_c[8*TX_ERRC_B +: 16] = err_cnt_q;
    tx_c[8*TX_CKS_B  +: 8]  = sum8(tx_c, TX_BYTES);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state and handshake strobes
  always_comb begin
    state_d   = state_q;
    ack_set   = 1'b0;
    send_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_rdy) begin
          state_d = S_ACK;
          ack_set = 1'b1;
        end
      end
      S_ACK:       state_d = S_EXEC;
      S_EXEC:      state_d = S_BUILD;
      S_BUILD:     state_d = S_SEND;
      S_SEND: begin
        if (bus.tx_rdy) begin
          state_d   = S_WAIT_BUSY;
          send_fire = 1'b1;
        end
      end
      S_WAIT_BUSY: state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.tx_rdy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // datapath: frame capture, checks, execution, counters and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q     <= '0;
      status_q    <= ST_OK;
      data_q      <= '0;
      rx_cnt_q    <= '0;
      err_cnt_q   <= '0;
      rx_ack_q    <= 1'b0;
      tx_vld_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      rx_ack_q    <= ack_set;
      tx_vld_q    <= send_fire;
      err_pulse_q <= 1'b0;
      if (ack_set) frame_q <= bus.rx_data;
      if (state_q == S_ACK) begin
        status_q <= status_c;
        rx_cnt_q <= rx_cnt_q + 16'd1;
      end
      if (state_q == S_EXEC) begin
        if (status_q != ST_OK) begin
          err_pulse_q <= 1'b1;
          data_q      <= '0;
          if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end else begin
          case (f_op)
            OP_WRITE: data_q <= f_data;
            OP_READ:  data_q <= rdata;
            default:  data_q <= {rx_cnt_q, err_cnt_q};
          endcase
        end
      end
      if (state_q == S_BUILD) tx_data_q <= tx_c;
    end
  end

endmodule
